median_window_11: RTL and testbench
===================================

# median_window_11

Streaming sliding-window front end for the 11-input median sorting network. It accepts one 32-bit sample per handshake and keeps the last 11 accepted samples in a shift register. It presents them as a registered 11-wide window (`data_0` oldest … `data_10` newest) with a valid/ready handshake, wired straight to the sorter's `data_*` inputs. A synchronous `flush` marks frame boundaries and restarts priming.

## Interface
Parameters:
- `WIN_LEN`, 11 — window length; fixed to the sorter width, elaborated only for 11.
- `SEQ_W`, 16 — width of the window sequence counter.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_data`  in  32 (`data_t`)  — input sample.
- `in_valid`  in  1  — sample offered.
- `in_ready`  out  1  — sample will be accepted this cycle.
- `flush`  in  1  — synchronous frame restart.
- `data_0` … `data_10`  out  32 each  — registered window, `data_0` oldest.
- `out_valid`  out  1  — window valid.
- `out_ready`  in  1  — consumer takes window.
- `win_seq`  out  `SEQ_W`  — index of the currently presented window.

## Operation
- Input accept: `in_valid && in_ready` at a rising edge. Output accept: `out_valid && out_ready` at a rising edge.
- `in_ready = !rst && !flush && (!out_valid || out_ready)`. This is combinational, with no dependency on `in_valid`.
- On input accept, the window shifts: `data_i <= data_{i+1}` for i = 0..9, then `data_10 <= in_data`.
- Fill counter `fill_cnt` (4 bits) runs 0..11 and saturates at 11.
- States:
  - EMPTY (`fill_cnt` = 0) -> FILL on accept.
  - FILL (1..10) -> FULL when the 11th sample is accepted.
  - FULL stays FULL.
  - Any state -> EMPTY on `flush`.
- `out_valid` is set at the edge of any accept that leaves the state FULL. It is cleared at an output accept that has no simultaneous input accept.
- A simultaneous output accept and input accept in FULL keeps `out_valid` high and presents the new window the next cycle.
- The window is stable while `out_valid && !out_ready`; in that case `in_ready` is 0.
- `win_seq` increments by 1 on each output accept and wraps from 2^SEQ_W−1 to 0.
- `flush` has priority over every other event:
  - `fill_cnt`, `out_valid`, `win_seq` and all `data_*` go to 0.
  - A same-cycle `in_valid` sample is not accepted, because `in_ready` is 0.
- Reset mid-frame is identical to flush, but asynchronous.

## Timing
- Reset values: `data_0`…`data_10` = 0, `out_valid` = 0, `win_seq` = 0, `fill_cnt` = 0. `in_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Latency: the sample accepted at edge k appears in `data_10` and drives `out_valid` from edge k, i.e. it is visible in cycle k+1.
- Throughput: one window per cycle in FULL with `out_ready` held high.
- Priming: the first `out_valid` follows the 11th accepted sample after reset or flush (without the macro).

## Configuration
Macro: `MEDIAN_WIN_EDGE_REPLICATE_EN`.
- Defined: the first sample accepted in EMPTY is written to all 11 slots. `fill_cnt` jumps to 11 and the state goes EMPTY -> FULL directly, so `out_valid` rises after the first sample.
- Undefined: normal priming as above.

## Structure
- Package `median_pkg`: `data_t` (32-bit logic), `WIN_LEN` = 11, the `fill_cnt` type, and the state enum `win_state_t` {EMPTY, FILL, FULL}.
- One sub-module, `median_win_shreg`: an 11-entry `data_t` shift register with shift-enable, clear and (under the macro) broadcast-load. The top module holds the FSM, the counter and the handshake.

## Test plan
- Prime: reset, then feed 1..11 with `out_ready`=1 -> `out_valid` first high after sample 11, window {1..11}, `win_seq`=0; the next edge sets `win_seq` to 1.
- Streaming: feed 12,13 continuously -> windows {2..12} then {3..13}, one per cycle, `in_ready` constant 1.
- Backpressure: in FULL, drop `out_ready` for 5 cycles while `in_valid`=1 -> window frozen, `in_ready`=0, no samples lost. Raising `out_ready` resumes with the next sample.
- Flush mid-frame: after 6 samples, assert `flush` together with `in_valid` (sample 99) -> 99 is not accepted, window is all zeros, and 11 new samples are needed before `out_valid`.
- Wrap: preload/run 65536 windows with `SEQ_W`=16 -> `win_seq` goes 65535 -> 0.
- Macro defined: reset, feed 7 -> next cycle window is eleven 7s and `out_valid`=1. Then feed 8 -> {7×10, 8}.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median_window_11 sliding-window front end.
//
// Contents:
//   data_t      - 32-bit sample type, also the sorter's data_* input type
//   WIN_LEN     - window length (fixed at the sorter width, 11)
//   fill_cnt_t  - 4-bit fill counter, saturates at WIN_LEN
//   win_state_t - window state: EMPTY, FILL, FULL
package median_pkg;

    typedef logic [31:0] data_t;

    localparam int WIN_LEN = 11;

    typedef logic [3:0] fill_cnt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } win_state_t;

endpackage

// File: rtl/median_window_11_if.sv
// Stream and window bundle of median_window_11.
//
// Handshake rule for both sides: a transfer happens at a rising clk edge where
// valid and ready are both high. ready never depends on valid. While a
// window is offered (out_valid=1) and not taken, the window is held stable.
//
// Signals:
//   in_data, in_valid, in_ready - input sample stream
//   flush                       - synchronous frame restart
//   data_0 .. data_10           - registered window, data_0 oldest
//   out_valid, out_ready        - window handshake
//   win_seq                     - index of the presented window
// Modports: master (sample source / window consumer), slave (the window block).
interface median_window_11_if
    import median_pkg::*;
#(
    parameter int SEQ_W = 16
);
    data_t            in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    data_t            data_0, data_1, data_2, data_3, data_4, data_5;
    data_t            data_6, data_7, data_8, data_9, data_10;
    logic             out_valid;
    logic             out_ready;
    logic [SEQ_W-1:0] win_seq;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_valid, win_seq,
        input  data_0, data_1, data_2, data_3, data_4, data_5,
        input  data_6, data_7, data_8, data_9, data_10
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_valid, win_seq,
        output data_0, data_1, data_2, data_3, data_4, data_5,
        output data_6, data_7, data_8, data_9, data_10
    );

endinterface

// File: rtl/median_win_shreg.sv
// WIN_LEN-entry sample shift register; q[0] oldest, q[WIN_LEN-1] newest.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears all entries)
//   clear     - synchronous clear of all entries, beats shifting
//   shift_en  - shift one place toward q[0] and load d into the newest slot
//   bcast     - (MEDIAN_WIN_EDGE_REPLICATE_EN only) with shift_en, load d
//               into every slot
//   d         - sample in
//   q         - window out
module median_win_shreg
    import median_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  shift_en,
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
    input  logic  bcast,
`endif
    input  data_t d,
    output data_t q [WIN_LEN]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_LEN; i++) q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN_LEN; i++) q[i] <= '0;
        end else if (shift_en) begin
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
            if (bcast) begin
                for (int i = 0; i < WIN_LEN; i++) q[i] <= d;
            end else begin
                for (int i = 0; i < WIN_LEN - 1; i++) q[i] <= q[i+1];
                q[WIN_LEN-1] <= d;
            end
`else
            for (int i = 0; i < WIN_LEN - 1; i++) q[i] <= q[i+1];
            q[WIN_LEN-1] <= d;
`endif
        end
    end

endmodule

// File: rtl/median_window_11.sv
// Streaming sliding-window front end for the 11-input median sorter.
// Keeps the last WIN_LEN accepted samples and offers them as one registered
// window with a valid/ready handshake and a wrapping window index.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - median_window_11_if.slave: sample stream, flush, window
//               outputs data_0..data_10, out_valid/out_ready, win_seq
//   dbg_state - current window state (EMPTY/FILL/FULL)
//
// Build option: MEDIAN_WIN_EDGE_REPLICATE_EN - the first sample after reset or
// flush fills every slot, so the first window is valid right after it.
module median_window_11 #(
    parameter int WIN_LEN = 11,
    parameter int SEQ_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    median_window_11_if.slave      bus,
    output median_pkg::win_state_t dbg_state
);
    import median_pkg::*;

    // The sorter behind this block is fixed at 11 inputs.
    if (WIN_LEN != median_pkg::WIN_LEN) begin : g_len_check
        $error("median_window_11 supports WIN_LEN = 11 only");
    end

    win_state_t       state;
    fill_cnt_t        fill_cnt;
    logic             out_valid_q;
    logic [SEQ_W-1:0] win_seq_q;
    data_t            win [WIN_LEN];

    logic in_acc;
    logic out_acc;

    // Ready is blocked by flush and by a held (untaken) window.
    assign bus.in_ready = !rst && !bus.flush && (!out_valid_q || bus.out_ready);
    assign in_acc       = bus.in_valid && bus.in_ready;
    assign out_acc      = out_valid_q && bus.out_ready;

    median_win_shreg u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.flush),
        .shift_en (in_acc),
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
        .bcast    (state == EMPTY),
`endif
        .d        (bus.in_data),
        .q        (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            fill_cnt    <= '0;
            out_valid_q <= 1'b0;
            win_seq_q   <= '0;
        end else if (bus.flush) begin
            state       <= EMPTY;
            fill_cnt    <= '0;
            out_valid_q <= 1'b0;
            win_seq_q   <= '0;
        end else begin
            if (out_acc) win_seq_q <= win_seq_q + SEQ_W'(1);

            if (in_acc) begin
                case (state)
                    EMPTY: begin
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
                        fill_cnt    <= fill_cnt_t'(WIN_LEN);
                        state       <= FULL;
                        out_valid_q <= 1'b1;
`else
                        fill_cnt    <= 4'd1;
                        state       <= FILL;
`endif
                    end
                    FILL: begin
                        if (fill_cnt == fill_cnt_t'(WIN_LEN - 1)) begin
                            fill_cnt    <= fill_cnt_t'(WIN_LEN);
                            state       <= FULL;
                            out_valid_q <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    FULL: begin
                        // New window replaces the old one; stay valid.
                        out_valid_q <= 1'b1;
                    end
                    default: begin
                        state    <= EMPTY;
                        fill_cnt <= '0;
                    end
                endcase
            end else if (out_acc) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.win_seq   = win_seq_q;
    assign dbg_state     = state;

    assign bus.data_0  = win[0];
    assign bus.data_1  = win[1];
    assign bus.data_2  = win[2];
    assign bus.data_3  = win[3];
    assign bus.data_4  = win[4];
    assign bus.data_5  = win[5];
    assign bus.data_6  = win[6];
    assign bus.data_7  = win[7];
    assign bus.data_8  = win[8];
    assign bus.data_9  = win[9];
    assign bus.data_10 = win[10];

endmodule

// File: tb/tb_median_window_11.sv
// Testbench for median_window_11. Honours MEDIAN_WIN_EDGE_REPLICATE_EN.
module tb_median_window_11;
    import median_pkg::*;

    localparam int SEQ_W = 16;
    localparam int W     = WIN_LEN * 32 + SEQ_W;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    win_state_t dbg_state;

    always #5 clk = ~clk;

    median_window_11_if #(.SEQ_W(SEQ_W)) bus ();

    median_window_11 #(.WIN_LEN(11), .SEQ_W(SEQ_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    data_t            hist_q[$];   // last WIN_LEN samples, oldest first
    int               acc_cnt;     // samples accepted since reset/flush
    bit               ov_m;
    logic [SEQ_W-1:0] seq_m;
    logic [W-1:0]     exp_q[$];    // {seq, window} of every window to be offered

    // Expectations for the cycle currently being presented.
    bit               snap_ok;
    bit               cur_rdy;
    bit               cur_ov;
    logic [SEQ_W-1:0] cur_seq;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] pack_model(input logic [SEQ_W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < WIN_LEN; i++) r[32*i +: 32] = hist_q[i];
        r[W-1 -: SEQ_W] = s;
        return r;
    endfunction

    function automatic logic [W-1:0] pack_dut();
        return {bus.win_seq, bus.data_10, bus.data_9, bus.data_8, bus.data_7,
                bus.data_6, bus.data_5, bus.data_4, bus.data_3, bus.data_2,
                bus.data_1, bus.data_0};
    endfunction

    function automatic void model_clear();
        hist_q.delete();
        repeat (WIN_LEN) hist_q.push_back('0);
        acc_cnt = 0;
        ov_m    = 1'b0;
        seq_m   = '0;
        exp_q.delete();
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit fl, input bit iv, input data_t d, input bit ordy);
        bit rdy;
        bit oacc;
        @(negedge clk);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        rdy     = !fl && (!ov_m || ordy);
        cur_rdy = rdy;
        cur_ov  = ov_m;
        cur_seq = seq_m;
        snap_ok = 1'b1;
        if (fl) begin
            model_clear();
        end else begin
            oacc = ov_m && ordy;
            if (oacc) seq_m = seq_m + 1'b1;
            if (iv && rdy) begin
`ifdef MEDIAN_WIN_EDGE_REPLICATE_EN
                if (acc_cnt == 0) begin
                    hist_q.delete();
                    repeat (WIN_LEN) hist_q.push_back(d);
                    acc_cnt = WIN_LEN;
                end else begin
                    hist_q.push_back(d);
                    void'(hist_q.pop_front());
                    acc_cnt++;
                end
`else
                hist_q.push_back(d);
                void'(hist_q.pop_front());
                acc_cnt++;
`endif
                if (acc_cnt >= WIN_LEN) begin
                    ov_m = 1'b1;
                    exp_q.push_back(pack_model(seq_m));
                end
            end else if (oacc) begin
                ov_m = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hdead_beef;
        bus.out_ready = 1'b1;
        snap_ok       = 1'b0;
        #2;
        check("rst_in_ready",  W'(bus.in_ready),  '0);
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_window",    pack_dut(),        '0);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(negedge clk);
        #2;
        if (!rst && snap_ok) begin
            snap_ok = 1'b0;
            check("in_ready",  W'(bus.in_ready),  W'(cur_rdy));
            check("out_valid", W'(bus.out_valid), W'(cur_ov));
            check("win_seq",   W'(bus.win_seq),   W'(cur_seq));
            if (bus.out_valid && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL window: got %h expected none queued", pack_dut());
                end else begin
                    check("window", pack_dut(), exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        snap_ok       = 1'b0;
        model_clear();

        // Prime with 1..11, then stream 12 and 13.
        do_reset();
        for (int i = 1; i <= 13; i++) drive(1'b0, 1'b1, data_t'(i), 1'b1);

        // Backpressure: sample 14 offered while the window is held.
        repeat (5) drive(1'b0, 1'b1, 32'd14, 1'b0);
        drive(1'b0, 1'b1, 32'd14, 1'b1);
        drive(1'b0, 1'b1, 32'd15, 1'b1);
        drive(1'b0, 1'b0, 32'd0,  1'b1);

        // Flush mid-frame with a same-cycle sample that must be dropped.
        do_reset();
        for (int i = 1; i <= 6; i++) drive(1'b0, 1'b1, data_t'(i + 40), 1'b1);
        drive(1'b1, 1'b1, 32'd99, 1'b1);
        @(posedge clk);
        #1;
        check("flush_window", pack_dut(), '0);
        check("flush_valid",  W'(bus.out_valid), '0);
        for (int i = 1; i <= 12; i++) drive(1'b0, 1'b1, data_t'(i + 60), 1'b1);

        // Mid-run asynchronous reset, then randomized traffic with flushes.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, $urandom, 1'b1);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                  $urandom, $urandom_range(0, 99) < 70);
        end

        // Long full-rate run to carry win_seq through 65535 -> 0.
        do_reset();
        for (int i = 0; i < 65536 + 20; i++) drive(1'b0, 1'b1, $urandom, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
